// File: rtl/mem_wb_stage.sv
// Memory-access plus MEM/WB stage: one M slot driving a req/ack data-memory port and a
// registered WB slot feeding the regfile write port. Optional macro: DM_TIMEOUT_EN.
module mem_wb_stage #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_regwrite,
   input  logic        ex_memtoreg,
   input  logic        ex_memwrite,
   input  logic [1:0]  ex_memsize,
   input  logic        ex_memsign,
   input  logic [31:0] ex_aluout,
   input  logic [31:0] ex_writedata,
   input  logic [4:0]  ex_writereg,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        we3,
   output logic [4:0]  wa3,
   output logic [31:0] wd3,
   output logic        misalign,
   output logic        dm_err
);

   // Handshake: an upstream instruction transfers on any rising edge where
   // ex_valid && ex_ready; a memory request transfers on the edge where dm_req && dm_ack.
   logic        m_valid;
   logic        m_regwrite;
   logic        m_memtoreg;
   logic        m_memwrite;
   logic [1:0]  m_memsize;
   logic        m_memsign;
   logic [31:0] m_aluout;
   logic [31:0] m_writedata;
   logic [4:0]  m_writereg;

   logic        m_mem;
   logic        aligned;
   logic        misaligned_op;
   logic        m_done;
   logic        accept;
   logic        timeout_fire;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] load_data;

   assign m_mem = m_memtoreg | m_memwrite;

   always_comb begin
      aligned = 1'b1;
      case (m_memsize)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~m_aluout[0];
         default: aligned = (m_aluout[1:0] == 2'b00);
      endcase
   end

   assign misaligned_op = m_valid & m_mem & ~aligned;
   assign dm_req        = m_valid & m_mem & aligned;
   assign dm_we         = m_memwrite;
   assign dm_addr       = {m_aluout[31:2], 2'b00};
   assign m_done        = m_valid & (~m_mem | ~aligned | dm_ack | timeout_fire);
   assign ex_ready      = ~m_valid | m_done;
   assign accept        = ex_valid & ex_ready;

   // Store data is replicated across lanes so the memory only has to honour dm_be.
   always_comb begin
      dm_be    = 4'b1111;
      dm_wdata = m_writedata;
      case (m_memsize)
         2'b00: begin
            dm_be    = 4'b0001 << m_aluout[1:0];
            dm_wdata = {4{m_writedata[7:0]}};
         end
         2'b01: begin
            dm_be    = m_aluout[1] ? 4'b1100 : 4'b0011;
            dm_wdata = {2{m_writedata[15:0]}};
         end
         default: begin
            dm_be    = 4'b1111;
            dm_wdata = m_writedata;
         end
      endcase
   end

   always_comb begin
      lb = 8'h00;
      case (m_aluout[1:0])
         2'b00: lb = dm_rdata[7:0];
         2'b01: lb = dm_rdata[15:8];
         2'b10: lb = dm_rdata[23:16];
         2'b11: lb = dm_rdata[31:24];
         default: lb = 8'h00;
      endcase
      lh = m_aluout[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (m_memsize)
         2'b00:   load_data = {{24{m_memsign & lb[7]}}, lb};
         2'b01:   load_data = {{16{m_memsign & lh[15]}}, lh};
         default: load_data = dm_rdata;
      endcase
   end

`ifdef DM_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // An ack in the fire cycle wins, so the instruction then retires normally.
   assign timeout_fire = dm_req & ~dm_ack & (wait_cnt == 8'(MAX_WAIT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 8'd0;
         dm_err   <= 1'b0;
      end else begin
         if (accept)
            wait_cnt <= 8'd0;
         else if (dm_req && !dm_ack)
            wait_cnt <= wait_cnt + 8'd1;
         if (timeout_fire)
            dm_err <= 1'b1;
      end
   end
`else
   localparam int max_wait_unused = MAX_WAIT;
   assign timeout_fire = 1'b0;
   assign dm_err       = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid     <= 1'b0;
         m_regwrite  <= 1'b0;
         m_memtoreg  <= 1'b0;
         m_memwrite  <= 1'b0;
         m_memsize   <= 2'b00;
         m_memsign   <= 1'b0;
         m_aluout    <= 32'd0;
         m_writedata <= 32'd0;
         m_writereg  <= 5'd0;
      end else if (accept) begin
         m_valid     <= 1'b1;
         m_regwrite  <= ex_regwrite;
         m_memtoreg  <= ex_memtoreg;
         m_memwrite  <= ex_memwrite;
         m_memsize   <= ex_memsize;
         m_memsign   <= ex_memsign;
         m_aluout    <= ex_aluout;
         m_writedata <= ex_writedata;
         m_writereg  <= ex_writereg;
      end else if (m_done) begin
         m_valid <= 1'b0;
      end
   end

   // we3 is a one-cycle pulse per retired instruction; wa3/wd3 hold between pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         we3      <= 1'b0;
         wa3      <= 5'd0;
         wd3      <= 32'd0;
         misalign <= 1'b0;
      end else begin
         if (m_done) begin
            we3 <= m_regwrite & (m_writereg != 5'd0) & ~(misaligned_op | timeout_fire);
            wa3 <= m_writereg;
            wd3 <= m_memtoreg ? load_data : m_aluout;
         end else begin
            we3 <= 1'b0;
         end
         if (misaligned_op)
            misalign <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps then a random instruction stream, checked
// against a byte-addressed memory model and expected queues.
module tb_mem_wb_stage;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_regwrite;
   logic        ex_memtoreg;
   logic        ex_memwrite;
   logic [1:0]  ex_memsize;
   logic        ex_memsign;
   logic [31:0] ex_aluout;
   logic [31:0] ex_writedata;
   logic [4:0]  ex_writereg;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = 32'd0;
   logic        we3;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic        misalign;
   logic        dm_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0]  dev_mem [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic [68:0] mem_q [$];
   logic [36:0] wb_q [$];
   int          wb_cyc [$];
   logic [4:0]  wb_wa [$];
   logic [68:0] mon_m;
   logic [36:0] mon_w;

   int ack_delay = 0;
   int wait_cnt  = 0;
   bit ack_never = 1'b0;
   bit rand_ack  = 1'b0;
   bit any_mis   = 1'b0;

   mem_wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
      .ex_memsize(ex_memsize), .ex_memsign(ex_memsign), .ex_aluout(ex_aluout),
      .ex_writedata(ex_writedata), .ex_writereg(ex_writereg),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .we3(we3), .wa3(wa3), .wd3(wd3), .misalign(misalign), .dm_err(dm_err)
   );

   // clock/reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Memory device: acks after ack_delay request cycles, may emit stray acks when idle.
   always @(negedge clk) begin
      if (!reset_n) begin
         wait_cnt = 0;
         dm_ack   = 1'b0;
      end else if (dm_req && !ack_never && wait_cnt >= ack_delay) begin
         int a;
         a = int'({dm_addr[9:2], 2'b00});
         dm_ack = 1'b1;
         if (dm_we) begin
            for (int k = 0; k < 4; k++)
               if (dm_be[k]) dev_mem[a + k] = dm_wdata[8*k +: 8];
            dm_rdata = $urandom;
         end else begin
            dm_rdata = {dev_mem[a + 3], dev_mem[a + 2], dev_mem[a + 1], dev_mem[a]};
         end
         wait_cnt = 0;
         if (rand_ack) ack_delay = $urandom_range(0, 3);
      end else begin
         if (dm_req) wait_cnt++;
         dm_ack   = !dm_req && rand_ack && ($urandom_range(0, 3) == 0);
         dm_rdata = $urandom;
      end
   end

   // Scoreboard: request fields and writebacks compared against expected queues.
   always @(negedge clk) begin
      #2;
      if (reset_n) begin
         if (dm_req) begin
            if (mem_q.size() == 0) begin
               chk("dm_req_unexpected", 32'(dm_req), 32'd0);
            end else begin
               mon_m = mem_q[0];
               chk("dm_we", 32'(dm_we), 32'(mon_m[68]));
               chk("dm_addr", dm_addr, mon_m[67:36]);
               if (mon_m[68]) begin
                  chk("dm_be", 32'(dm_be), 32'(mon_m[35:32]));
                  chk("dm_wdata", dm_wdata, mon_m[31:0]);
               end
               if (dm_ack) void'(mem_q.pop_front());
            end
         end
         if (we3) begin
            wb_cyc.push_back(cyc);
            wb_wa.push_back(wa3);
            if (wb_q.size() == 0) begin
               chk("we3_unexpected", 32'(we3), 32'd0);
            end else begin
               mon_w = wb_q.pop_front();
               chk("wa3", 32'(wa3), 32'(mon_w[36:32]));
               chk("wd3", wd3, mon_w[31:0]);
            end
         end
      end
   end

   task automatic to_sample(input int k);
      repeat (k) @(posedge clk);
      @(negedge clk);
      #3;
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Driver: presents one instruction and, on acceptance, updates the reference model.
   task automatic send(input logic rw, input logic mtr, input logic mw, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [4:0] wr);
      int          n, a, t;
      bit          mis, accepted;
      logic [31:0] v, wl;
      logic [3:0]  be;
      ex_valid = 1'b1; ex_regwrite = rw; ex_memtoreg = mtr; ex_memwrite = mw;
      ex_memsize = sz; ex_memsign = sgn; ex_aluout = addr; ex_writedata = wdat;
      ex_writereg = wr;
      accepted = 1'b0;
      t = 0;
      while (!accepted && t < 64) begin
         to_sample(0);
         if (ex_ready) begin
            accepted = 1'b1;
            n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            a   = int'(addr[9:0]);
            mis = (mtr || mw) && ((int'(addr[1:0]) % n) != 0);
            v   = 32'd0;
            if (mis) begin
               any_mis = 1'b1;
            end else if (mtr || mw) begin
               be = 4'b0000;
               for (int i = 0; i < n; i++) be[(a % 4) + i] = 1'b1;
               for (int k = 0; k < 4; k++) wl[8*k +: 8] = wdat[8*(k % n) +: 8];
               mem_q.push_back({mw, addr & 32'hFFFF_FFFC, be, wl});
               if (mw)
                  for (int i = 0; i < n; i++) ref_mem[a + i] = wdat[8*i +: 8];
               if (mtr) begin
                  for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
                  if (sgn && n < 4 && v[8*n - 1])
                     for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
               end
            end
            if (rw && wr != 5'd0 && !mis)
               wb_q.push_back({wr, mtr ? v : addr});
         end
         to_drive();
         t++;
      end
      ex_valid = 1'b0;
      chk("ex_accept", 32'(accepted), 32'd1);
   endtask

   initial begin
      int req_n, nrdy, we_n;
      logic [7:0] b;
      for (int i = 0; i < 1024; i++) begin
         b = 8'($urandom);
         dev_mem[i] = b;
         ref_mem[i] = b;
      end
      reset_n = 1'b0; ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memtoreg = 1'b0;
      ex_memwrite = 1'b0; ex_memsize = 2'b00; ex_memsign = 1'b0; ex_aluout = 32'd0;
      ex_writedata = 32'd0; ex_writereg = 5'd0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // reset state
      to_sample(0);
      chk("rst_we3", 32'(we3), 32'd0);
      chk("rst_wa3", 32'(wa3), 32'd0);
      chk("rst_wd3", wd3, 32'd0);
      chk("rst_dm_req", 32'(dm_req), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_dm_err", 32'(dm_err), 32'd0);
      chk("rst_ex_ready", 32'(ex_ready), 32'd1);
      to_drive();

      // ALU op writes one cycle after accept, no memory request
      send(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'd0, 5'd8);
      to_sample(0);
      chk("alu_no_req", 32'(dm_req), 32'd0);
      to_sample(1);
      chk("alu_we3", 32'(we3), 32'd1);
      chk("alu_wa3", 32'(wa3), 32'd8);
      chk("alu_wd3", wd3, 32'h1234_5678);
      to_drive();

      // LB signed and LHU from word 0x80FF1234 at 0x100
      ref_mem[256] = 8'h34; ref_mem[257] = 8'h12; ref_mem[258] = 8'hFF; ref_mem[259] = 8'h80;
      dev_mem[256] = 8'h34; dev_mem[257] = 8'h12; dev_mem[258] = 8'hFF; dev_mem[259] = 8'h80;
      send(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 5'd9);
      to_sample(0);
      chk("lb_req", 32'(dm_req), 32'd1);
      chk("lb_addr", dm_addr, 32'h100);
      to_sample(1);
      chk("lb_we3", 32'(we3), 32'd1);
      chk("lb_wd3", wd3, 32'hFFFF_FF80);
      to_drive();
      send(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 5'd10);
      to_sample(1);
      chk("lhu_wd3", wd3, 32'h0000_80FF);
      to_drive();

      // SH with ack after 3 waiting cycles
      ack_delay = 3;
      send(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'hAAAA_BEEF, 5'd0);
      req_n = 0; nrdy = 0; we_n = 0;
      for (int i = 0; i < 6; i++) begin
         to_sample((i == 0) ? 0 : 1);
         if (i == 0) begin
            chk("sh_be", 32'(dm_be), 32'h0000_000C);
            chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
         end
         req_n += int'(dm_req);
         nrdy  += int'(!ex_ready);
         we_n  += int'(we3);
      end
      chk("sh_req_cycles", 32'(req_n), 32'd4);
      chk("sh_stall_cycles", 32'(nrdy), 32'd3);
      chk("sh_no_write", 32'(we_n), 32'd0);
      to_drive();
      ack_delay = 0;

      // misaligned LW, then a normal ALU op
      send(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 5'd11);
      to_sample(0);
      chk("mis_no_req", 32'(dm_req), 32'd0);
      chk("mis_ready", 32'(ex_ready), 32'd1);
      to_sample(1);
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_no_we3", 32'(we3), 32'd0);
      to_drive();
      send(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'hCAFE_0001, 32'd0, 5'd12);
      to_sample(1);
      chk("post_mis_we3", 32'(we3), 32'd1);
      chk("post_mis_wd3", wd3, 32'hCAFE_0001);
      to_drive();

      // back-to-back loads with immediate ack, then a write to r0
      wb_cyc.delete(); wb_wa.delete();
      for (int i = 0; i < 4; i++)
         send(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 5'(i + 1));
      send(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h5555_AAAA, 32'd0, 5'd0);
      to_sample(3);
      to_drive();
      chk("b2b_count", 32'(wb_wa.size()), 32'd4);
      for (int i = 0; i < wb_wa.size() && i < 4; i++) begin
         chk("b2b_wa3", 32'(wb_wa[i]), 32'(i + 1));
         chk("b2b_consecutive", 32'(wb_cyc[i]), 32'(wb_cyc[0] + i));
      end

`ifdef DM_TIMEOUT_EN
      // memory never acks: request times out after MAX_WAIT cycles
      ack_never = 1'b1;
      wb_cyc.delete(); wb_wa.delete();
      send(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 5'd13);
      req_n = 0;
      for (int i = 0; i < 8; i++) begin
         to_sample((i == 0) ? 0 : 1);
         req_n += int'(dm_req);
      end
      chk("to_req_cycles", 32'(req_n), 32'(MAX_WAIT));
      chk("to_dm_err", 32'(dm_err), 32'd1);
      chk("to_no_write", 32'(wb_cyc.size()), 32'd0);
      to_drive();
      mem_q.delete(); wb_q.delete();
      ack_never = 1'b0;
`endif

      // reset in the middle of an outstanding load
      ack_delay = 5;
      send(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h84, 32'd0, 5'd14);
      to_sample(1);
      chk("mid_req_active", 32'(dm_req), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_we3", 32'(we3), 32'd0);
      chk("mid_rst_wa3", 32'(wa3), 32'd0);
      chk("mid_rst_wd3", wd3, 32'd0);
      chk("mid_rst_req", 32'(dm_req), 32'd0);
      chk("mid_rst_misalign", 32'(misalign), 32'd0);
      chk("mid_rst_dm_err", 32'(dm_err), 32'd0);
      chk("mid_rst_ready", 32'(ex_ready), 32'd1);
      mem_q.delete(); wb_q.delete();
      any_mis = 1'b0;
      ack_delay = 0;
      to_drive();
      reset_n = 1'b1;
      to_drive();

      // random instruction stream with random ack latency and stray acks
      rand_ack = 1'b1;
      for (int it = 0; it < 200; it++) begin
         int kind, n, base;
         logic [1:0]  sz;
         logic [31:0] addr;
         kind = $urandom_range(0, 2);
         sz   = 2'($urandom_range(0, 3));
         n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         base = $urandom_range(0, 1019);
         if ($urandom_range(0, 7) != 0) base = base - (base % n);
         addr = (kind == 0) ? $urandom : 32'(base);
         send(1'($urandom_range(0, 1)), kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)),
              addr, $urandom, 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) to_drive();
      end
      to_sample(12);
      to_drive();
      rand_ack = 1'b0;
      chk("rand_wb_drained", 32'(wb_q.size()), 32'd0);
      chk("rand_mem_drained", 32'(mem_q.size()), 32'd0);
      chk("rand_misalign", 32'(misalign), 32'(any_mis));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
